// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: per-channel LED pattern generator
// modes OFF / ON / BLINK / BURST with done pulse
module led_pattern_ctrl #(
  parameter int N_CH     = 4,
  parameter int HALF_CYC = 62_500_000,
  parameter int CNT_W    = 32,
  parameter int BURST_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [2*N_CH-1:0]   mode,
  input  logic [N_CH-1:0]     restart,
  input  logic [BURST_W-1:0]  burst_n,
  output logic [N_CH-1:0]     led,
  output logic [N_CH-1:0]     busy,
  output logic [N_CH-1:0]     done
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(HALF_CYC - 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_ON,
    S_BLINK,
    S_BURST,
    S_DONE
  } state_t;

  state_t             st_q  [N_CH];
  state_t             st_d  [N_CH];
  logic [1:0]         mq_q  [N_CH];
  logic [1:0]         mq_d  [N_CH];
  logic [CNT_W-1:0]   cnt_q [N_CH];
  logic [CNT_W-1:0]   cnt_d [N_CH];
  logic [BURST_W-1:0] rem_q [N_CH];
  logic [BURST_W-1:0] rem_d [N_CH];
  logic [N_CH-1:0]    led_d;
  logic [N_CH-1:0]    busy_d;
  logic [N_CH-1:0]    done_d;

  // next-state and output decode, one channel per iteration
  always_comb begin : nxt
    logic [1:0] m;
    logic       ent;
    logic       lst;
    m      = '0;
    ent    = 1'b0;
    lst    = 1'b0;
    led_d  = led;
    busy_d = busy;
    done_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      st_d[i]  = st_q[i];
      mq_d[i]  = mq_q[i];
      cnt_d[i] = cnt_q[i];
      rem_d[i] = rem_q[i];
      m   = mode[2*i +: 2];
      ent = (m != mq_q[i]) || restart[i];
      lst = (cnt_q[i] == LAST);
      if (!en) begin
        st_d[i]   = S_OFF;
        mq_d[i]   = 2'b00;
        cnt_d[i]  = '0;
        led_d[i]  = 1'b0;
        busy_d[i] = 1'b0;
      end else if (ent) begin
        mq_d[i]  = m;
        cnt_d[i] = '0;
        unique case (m)
          2'b00: begin
            st_d[i]   = S_OFF;
            led_d[i]  = 1'b0;
            busy_d[i] = 1'b0;
          end
          2'b01: begin
            st_d[i]   = S_ON;
            led_d[i]  = 1'b1;
            busy_d[i] = 1'b0;
          end
          2'b10: begin
            st_d[i]   = S_BLINK;
            led_d[i]  = 1'b1;
            busy_d[i] = 1'b0;
          end
          default: begin
            rem_d[i] = burst_n;
            if (burst_n == '0) begin
              st_d[i]   = S_DONE;
              led_d[i]  = 1'b0;
              busy_d[i] = 1'b0;
              done_d[i] = 1'b1;
            end else begin
              st_d[i]   = S_BURST;
              led_d[i]  = 1'b1;
              busy_d[i] = 1'b1;
            end
          end
        endcase
      end else begin
        unique case (1'b1)
          (st_q[i] == S_BLINK): begin
            if (lst) begin
              cnt_d[i] = '0;
              led_d[i] = ~led[i];
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          (st_q[i] == S_BURST): begin
            if (lst) begin
              cnt_d[i] = '0;
              if (led[i]) begin
                led_d[i] = 1'b0;
              end else begin
                rem_d[i] = rem_q[i] - BURST_W'(1);
                if (rem_q[i] == BURST_W'(1)) begin
                  st_d[i]   = S_DONE;
                  busy_d[i] = 1'b0;
                  done_d[i] = 1'b1;
                end else begin
                  led_d[i] = 1'b1;
                end
              end
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          (st_q[i] == S_DONE): begin
            cnt_d[i] = '0;
            led_d[i] = 1'b0;
          end
          default: begin
            cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  // channel state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led  <= '0;
      busy <= '0;
      done <= '0;
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]  <= S_OFF;
        mq_q[i]  <= 2'b00;
        cnt_q[i] <= '0;
        rem_q[i] <= '0;
      end
    end else begin
      led  <= led_d;
      busy <= busy_d;
      done <= done_d;
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]  <= st_d[i];
        mq_q[i]  <= mq_d[i];
        cnt_q[i] <= cnt_d[i];
        rem_q[i] <= rem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: table vectors plus
// directed corner sequences
module tb_led_pattern_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] mode;
  logic [3:0] restart;
  logic [3:0] burst_n;
  logic [3:0] led;
  logic [3:0] busy;
  logic [3:0] done;

  logic       en2;
  logic [7:0] mode2;
  logic [3:0] restart2;
  logic [3:0] burst_n2;
  logic [3:0] led2;
  logic [3:0] busy2;
  logic [3:0] done2;

  int checks;
  int failures;

  led_pattern_ctrl #(
    .N_CH(4), .HALF_CYC(4),
    .CNT_W(32), .BURST_W(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .mode(mode), .restart(restart),
    .burst_n(burst_n), .led(led),
    .busy(busy), .done(done)
  );

  led_pattern_ctrl #(
    .N_CH(4), .HALF_CYC(1),
    .CNT_W(32), .BURST_W(4)
  ) dut1 (
    .clk(clk), .rst(rst), .en(en2),
    .mode(mode2), .restart(restart2),
    .burst_n(burst_n2), .led(led2),
    .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:0] mode;
    logic [3:0] rs;
    logic [3:0] bn;
    logic [3:0] led;
    logic [3:0] busy;
    logic [3:0] done;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(
    input logic       e,
    input logic [7:0] m,
    input logic [3:0] r,
    input logic [3:0] b,
    input logic [3:0] l,
    input logic [3:0] bu,
    input logic [3:0] d
  );
    vec_t v;
    v.en   = e;
    v.mode = m;
    v.rs   = r;
    v.bn   = b;
    v.led  = l;
    v.busy = bu;
    v.done = d;
    tbl.push_back(v);
  endfunction

  task automatic chk(
    input string       nm,
    input logic [11:0] got,
    input logic [11:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h",
               nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_o(
    input string      nm,
    input logic [3:0] l,
    input logic [3:0] b,
    input logic [3:0] d
  );
    chk(nm, {led, busy, done}, {l, b, d});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    en       = 1'b0;
    mode     = '0;
    restart  = '0;
    burst_n  = '0;
    en2      = 1'b0;
    mode2    = '0;
    restart2 = '0;
    burst_n2 = '0;
    #1;
    chk_o("rst_async", 4'h0, 4'h0, 4'h0);
    #11;
    rst = 1'b0;
    step();
    chk_o("rst_state", 4'h0, 4'h0, 4'h0);

    // reset in the middle of a burst
    en      = 1'b1;
    mode    = 8'h31;
    burst_n = 4'd2;
    step();
    chk_o("pre_rst", 4'b0101, 4'b0100, 4'h0);
    step();
    step();
    #2;
    rst  = 1'b1;
    mode = 8'h01;
    #1;
    chk_o("rst_mid", 4'h0, 4'h0, 4'h0);
    #1;
    rst = 1'b0;
    step();
    chk_o("post_rst_on", 4'b0001, 4'h0, 4'h0);
    for (int k = 0; k < 20; k++) begin
      step();
      chk_o($sformatf("rst_nodone%0d", k),
            4'b0001, 4'h0, 4'h0);
    end

    // table: blink ch1, burst ch2 twice
    add(1, 8'h00, 0, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++)
      add(1, 8'h08, 0, 0,
          ((k % 8) < 4) ? 4'b0010 : 4'b0,
          0, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0);
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 18; k++) begin
        add(1, 8'h30,
            (p == 1 && k == 0) ? 4'b0100 : 4'b0,
            (k > 2) ? 4'd5 : 4'd2,
            (k < 16 && ((k / 4) % 2) == 0)
              ? 4'b0100 : 4'b0,
            (k < 16) ? 4'b0100 : 4'b0,
            (k == 16) ? 4'b0100 : 4'b0);
      end
    end
    add(1, 8'h00, 0, 0, 0, 0, 0);

    foreach (tbl[k]) begin
      en      = tbl[k].en;
      mode    = tbl[k].mode;
      restart = tbl[k].rs;
      burst_n = tbl[k].bn;
      step();
      chk_o($sformatf("tbl%0d", k),
            tbl[k].led, tbl[k].busy,
            tbl[k].done);
    end
    restart = '0;

    // ch3: burst with zero count
    mode    = 8'hC0;
    burst_n = 4'd0;
    step();
    chk_o("b0_done", 4'h0, 4'h0, 4'b1000);
    step();
    chk_o("b0_after", 4'h0, 4'h0, 4'h0);

    // ch3: burst then switch to blink
    burst_n = 4'd3;
    restart = 4'b1000;
    step();
    restart = '0;
    chk_o("b3_entry", 4'b1000, 4'b1000, 4'h0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_o($sformatf("b3_run%0d", k),
            (k < 4) ? 4'b1000 : 4'b0,
            4'b1000, 4'h0);
    end
    mode = 8'h80;
    step();
    chk_o("sw_blink", 4'b1000, 4'h0, 4'h0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_o($sformatf("sw_run%0d", k),
            (k < 4) ? 4'b1000 : 4'b0,
            4'h0, 4'h0);
    end

    // ch3: restart with mode change
    mode    = 8'hC0;
    burst_n = 4'd1;
    restart = 4'b1000;
    step();
    restart = '0;
    chk_o("rm_entry", 4'b1000, 4'b1000, 4'h0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_o($sformatf("rm_run%0d", k),
            (k < 4) ? 4'b1000 : 4'b0,
            (k < 8) ? 4'b1000 : 4'b0,
            (k == 8) ? 4'b1000 : 4'b0);
    end

    // global enable drop mid-burst
    mode    = 8'h39;
    burst_n = 4'd2;
    step();
    chk_o("en_entry", 4'b0111, 4'b0100, 4'h0);
    for (int k = 1; k <= 5; k++) step();
    chk_o("en_mid", 4'b0001, 4'b0100, 4'h0);
    en = 1'b0;
    step();
    chk_o("en_off", 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < 20; k++) begin
      step();
      chk_o($sformatf("en_hold%0d", k),
            4'h0, 4'h0, 4'h0);
    end
    en = 1'b1;
    step();
    chk_o("en_back", 4'b0111, 4'b0100, 4'h0);
    for (int k = 1; k <= 4; k++) step();
    chk_o("en_back4", 4'b0001, 4'b0100, 4'h0);

    // HALF_CYC=1: toggle every cycle
    en2   = 1'b1;
    mode2 = 8'h02;
    step();
    chk("h1_entry", {8'h0, led2},
        {8'h0, 4'b0001});
    for (int k = 1; k <= 8; k++) begin
      logic [3:0] ex;
      if (k == 2) mode2 = 8'h0A;
      if (k == 3) mode2 = 8'h2A;
      ex    = '0;
      ex[0] = (k % 2) == 0;
      if (k >= 2) ex[1] = ((k - 2) % 2) == 0;
      if (k >= 3) ex[2] = ((k - 3) % 2) == 0;
      step();
      chk($sformatf("h1_run%0d", k),
          {busy2, done2, led2},
          {8'h0, ex});
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
